rvv_backend_uop_queue: RTL and testbench
========================================

// Module: rvv_backend_uop_queue
// PURPOSE
//  Multi-port uop FIFO between decode and dispatch; receives the push side of the decode stage.
//  Each cycle: up to NUM_WR uops written and up to NUM_RD uops read.
//  Emits full/almost_full to decode and empty/almost_empty to the reader.
//  Read data is first-word fall-through.
// PARAMETERS
//  DWIDTH  $bits(UOP_QUEUE_t)  payload width per entry
//  DEPTH   16                  entries; power of 2, DEPTH >= NUM_WR and DEPTH >= NUM_RD
//  NUM_WR  `NUM_DE_UOP (4)     write ports
//  NUM_RD  2                   read ports
//  CW      $clog2(DEPTH+1)     width of count
// PORTS
//  clk           in   1              clock; all state updates on rising edge
//  rst_n         in   1              synchronous reset, active-low
//  push          in   NUM_WR         per-slot write request
//  datain        in   NUM_WR*DWIDTH  per-slot write payload
//  full          out  1              count == DEPTH
//  almost_full   out  NUM_WR         [i] = (DEPTH-count) < i+1
//  pop           in   NUM_RD         per-slot read request
//  dataout       out  NUM_RD*DWIDTH  [i] = mem[(rptr+i) mod DEPTH]
//  empty         out  1              count == 0
//  almost_empty  out  NUM_RD         [i] = count < i+1
//  count         out  CW             occupied entries
// BEHAVIOUR
//  - State: mem[DEPTH] (not reset), wptr, rptr (log2 DEPTH bits, wrap mod DEPTH), cnt (CW bits).
//  - Reset (rst_n=0 at posedge) sets wptr=rptr=cnt=0. Outputs after reset:
//      empty=1, almost_empty=all 1, full=0, almost_full=all 0, count=0, dataout=don't-care.
//  - All flags decode combinationally from registered cnt; no flag depends on push or pop.
//    almost_full[0]==full and almost_empty[0]==empty.
//  - Write acceptance: wacc[0] = push[0] & !almost_full[0];
//    wacc[i] = push[i] & !almost_full[i] & wacc[i-1].
//    nw = number of set wacc bits. Writes mem[(wptr+k) mod DEPTH] <= datain[k] for k<nw;
//    wptr += nw (wraps).
//  - Read acceptance: racc[i] = pop[i] & !almost_empty[i] & racc[i-1] (same rule); nr = count of racc;
//    rptr += nr (wraps).
//  - cnt_next = cnt + nw - nr; both applied in the same cycle.
//    A slot freed by a pop is not writable until the next cycle (flags use old cnt).
//  - Latency: an entry written in cycle N is visible on dataout[0] in cycle N+1 if the queue was empty.
//    Pop has no extra latency.
//  - dataout[i] is valid only while almost_empty[i]==0; it is don't-care otherwise.
//  - Protocol violations: non-contiguous push/pop (e.g. push=4'b0101), push[i] with almost_full[i],
//    pop[i] with almost_empty[i].
//    The RTL silently drops the non-accepted slots per the acceptance rules above;
//    an SVA (rvv_backend_sva.svh macros) flags each case.
//  - No state machine beyond the pointers and count; cnt never exceeds DEPTH and never underflows.
//  - Reset while push/pop are active: reset wins; no write or read takes effect that cycle.
// TESTING
//  1. Reset, then push=4'b1111 with data A..D -> next cycle count=4, dataout[0]=A, dataout[1]=B,
//     empty=0, almost_empty=2'b00.
//  2. Fill to count=14, push=4'b1111 -> almost_full=4'b1100; only 2 uops accepted; count=16; full=1.
//  3. count=16, pop=2'b11 and push=4'b0001 same cycle -> push dropped (full seen), count=14,
//     assertion fires.
//  4. Wrap-around: 40 cycles of push 3 / pop 2 with random data -> output order matches a scoreboard,
//     pointers wrap at 16.
//  5. count=1, pop=2'b11 -> only slot 0 accepted, count=0, empty=1; assert on pop[1].
//  6. Queue half full, assert rst_n=0 for one cycle with push/pop active -> count=0, empty=1,
//     full=0 the next cycle.

Source files
------------

// File: rtl/rvv_backend_uop_queue.sv
// rvv_backend_uop_queue: multi-port first-word-fall-through uop FIFO between decode and dispatch
module rvv_backend_uop_queue #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 2,
    parameter int CW     = $clog2(DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        push,
    input  logic [NUM_WR*DWIDTH-1:0] datain,
    output logic                     full,
    output logic [NUM_WR-1:0]        almost_full,
    input  logic [NUM_RD-1:0]        pop,
    output logic [NUM_RD*DWIDTH-1:0] dataout,
    output logic                     empty,
    output logic [NUM_RD-1:0]        almost_empty,
    output logic [CW-1:0]            count
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d, nw, nr;
    logic [NUM_WR-1:0] wacc;
    logic [NUM_RD-1:0] racc;
    logic              ok_w, ok_r;

    assign count = cnt_q;

    // Flags and FWFT read data decode only from registered state
    always_comb begin
        full         = cnt_q == CW'(DEPTH);
        empty        = cnt_q == '0;
        almost_full  = '0;
        almost_empty = '0;
        dataout      = '0;
        for (int i = 0; i < NUM_WR; i++) almost_full[i] = (CW'(DEPTH) - cnt_q) < CW'(i+1);
        for (int i = 0; i < NUM_RD; i++) begin
            almost_empty[i]                 = cnt_q < CW'(i+1);
            dataout[i*DWIDTH +: DWIDTH]     = mem_q[rptr_q + AW'(i)];
        end
    end

    // Contiguous-prefix acceptance on both sides; pointer, count and memory next state
    always_comb begin
        mem_d = mem_q;
        ok_w  = 1'b1;
        ok_r  = 1'b1;
        nw    = '0;
        nr    = '0;
        wacc  = '0;
        racc  = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            ok_w    = ok_w & push[k] & ~almost_full[k];
            wacc[k] = ok_w;
            nw      = nw + CW'(wacc[k]);
            if (wacc[k]) mem_d[wptr_q + AW'(k)] = datain[k*DWIDTH +: DWIDTH];
        end
        for (int k = 0; k < NUM_RD; k++) begin
            ok_r    = ok_r & pop[k] & ~almost_empty[k];
            racc[k] = ok_r;
            nr      = nr + CW'(racc[k]);
        end
        wptr_d = wptr_q + AW'(nw);
        rptr_d = rptr_q + AW'(nr);
        cnt_d  = cnt_q + nw - nr;
    end

    // State update; reset suppresses any write or read in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// tb_rvv_backend_uop_queue: directed scoreboard bench for the multi-port uop queue
module tb_rvv_backend_uop_queue;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   push = '0;
    logic [127:0] datain = '0;
    logic [1:0]   pop = '0;
    logic         full, empty;
    logic [3:0]   almost_full;
    logic [1:0]   almost_empty;
    logic [63:0]  dataout;
    logic [4:0]   count;

    int          total = 0;
    int          bad = 0;
    int          mcnt = 0;
    int          exp_nr = 0;
    logic [31:0] expq[$];

    rvv_backend_uop_queue #(.DWIDTH(32), .DEPTH(16), .NUM_WR(4), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .datain(datain), .full(full),
        .almost_full(almost_full), .pop(pop), .dataout(dataout), .empty(empty),
        .almost_empty(almost_empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: compares every read the scoreboard expects in this cycle
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < exp_nr; i++) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_underrun: slot %0d has no expected entry", i);
                end else chk($sformatf("rd_data%0d", i), dataout[i*32 +: 32], expq.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] p, input logic [127:0] d, input logic [1:0] q);
        bit ok;
        int nw, nr;
        push = p;
        datain = d;
        pop = q;
        ok = 1;
        nw = 0;
        nr = 0;
        for (int k = 0; k < 4; k++) begin
            ok = ok && p[k] && (16 - mcnt >= k + 1);
            if (ok) begin
                expq.push_back(d[k*32 +: 32]);
                nw++;
            end
        end
        ok = 1;
        for (int i = 0; i < 2; i++) begin
            ok = ok && q[i] && (mcnt >= i + 1);
            if (ok) nr++;
        end
        exp_nr = nr;
        mcnt = mcnt + nw - nr;
        @(posedge clk);
        #1;
        exp_nr = 0;
        chk("count", count, mcnt);
        chk("full", full, mcnt == 16);
        chk("empty", empty, mcnt == 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 2'b11);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 4'b0000);
        rst_n = 1'b1;
        // 1: four writes, FWFT visible next cycle
        step(4'b1111, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 2'b00);
        chk("t1_count", count, 4);
        chk("t1_do0", dataout[31:0], 32'hAAAA_0001);
        chk("t1_do1", dataout[63:32], 32'hBBBB_0002);
        chk("t1_aempty", almost_empty, 2'b00);
        // 2: fill to 14 then a 4-wide push only takes 2
        step(4'b1111, {32'h14, 32'h13, 32'h12, 32'h11}, 2'b00);
        step(4'b1111, {32'h24, 32'h23, 32'h22, 32'h21}, 2'b00);
        step(4'b0011, {32'h0, 32'h0, 32'h32, 32'h31}, 2'b00);
        chk("t2_count14", count, 14);
        chk("t2_afull", almost_full, 4'b1100);
        step(4'b1111, {32'h44, 32'h43, 32'h42, 32'h41}, 2'b00);
        chk("t2_count16", count, 16);
        chk("t2_full", full, 1);
        chk("t2_afull_all", almost_full, 4'b1111);
        // 3: push while full is dropped even with a simultaneous pop
        step(4'b0001, {96'h0, 32'hDEAD_BEEF}, 2'b11);
        chk("t3_count", count, 14);
        chk("t3_full", full, 0);
        // 4: drain to 4, then sustained push 3 / pop 2 across pointer wrap
        repeat (5) step(4'b0000, 128'h0, 2'b11);
        chk("t4_count4", count, 4);
        repeat (40) step(4'b0111, {$urandom, $urandom, $urandom, $urandom}, 2'b11);
        for (int n = 0; n < 20 && mcnt > 0; n++) step(4'b0000, 128'h0, 2'b11);
        chk("t4_empty", empty, 1);
        // 5: pop of two with one entry only takes one
        step(4'b0001, {96'h0, 32'h5555_5555}, 2'b00);
        step(4'b0000, 128'h0, 2'b11);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_aempty", almost_empty, 2'b11);
        // 6: reset with push/pop active wins
        step(4'b1111, {32'h64, 32'h63, 32'h62, 32'h61}, 2'b00);
        step(4'b1111, {32'h74, 32'h73, 32'h72, 32'h71}, 2'b00);
        chk("t6_count8", count, 8);
        rst_n = 1'b0;
        push = 4'b1111;
        pop = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push = '0;
        pop = '0;
        expq.delete();
        mcnt = 0;
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_full", full, 0);
        step(4'b0001, {96'h0, 32'h7777_0007}, 2'b00);
        chk("t6_do0", dataout[31:0], 32'h7777_0007);
        step(4'b0000, 128'h0, 2'b01);
        step(4'b0000, 128'h0, 2'b00);
        chk("scoreboard_left", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
